// File: rtl/logic_pipe.sv
// logic_pipe: elastic DEPTH-stage pipeline around an eight-function bitwise logic unit.
// Valid/ready handshakes on both sides; bubbles compact under backpressure; counts delivered results.
module logic_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count
);
    localparam logic [2:0] OP_NOT_A = 3'd0;
    localparam logic [2:0] OP_AND   = 3'd1;
    localparam logic [2:0] OP_OR    = 3'd2;
    localparam logic [2:0] OP_XOR   = 3'd3;
    localparam logic [2:0] OP_NAND  = 3'd4;
    localparam logic [2:0] OP_NOR   = 3'd5;
    localparam logic [2:0] OP_XNOR  = 3'd6;
    localparam logic [2:0] OP_PASS  = 3'd7;

    logic [WIDTH-1:0] func_result;
    logic [DEPTH-1:0] v_reg;
    logic [DEPTH-1:0] v_next;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] d_reg  [DEPTH];
    logic [WIDTH-1:0] d_next [DEPTH];
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             out_fire;

    always_comb begin
        func_result = in_a;
        case (in_op)
            OP_NOT_A: func_result = ~in_a;
            OP_AND:   func_result = in_a & in_b;
            OP_OR:    func_result = in_a | in_b;
            OP_XOR:   func_result = in_a ^ in_b;
            OP_NAND:  func_result = ~(in_a & in_b);
            OP_NOR:   func_result = ~(in_a | in_b);
            OP_XNOR:  func_result = ~(in_a ^ in_b);
            OP_PASS:  func_result = in_a;
            default:  func_result = in_a;
        endcase
    end

    // A stage may advance if its downstream neighbour advances or it holds nothing,
    // so any empty slot ahead lets everything behind it move up.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = out_ready | ~v_reg[DEPTH-1];
        for (int s = DEPTH - 2; s >= 0; s--) begin
            adv[s] = adv[s+1] | ~v_reg[s];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign v_next[gi] = adv[gi] ? in_valid    : v_reg[gi];
                assign d_next[gi] = adv[gi] ? func_result : d_reg[gi];
            end else begin : g_body
                assign v_next[gi] = adv[gi] ? v_reg[gi-1] : v_reg[gi];
                assign d_next[gi] = adv[gi] ? d_reg[gi-1] : d_reg[gi];
            end
        end
    endgenerate

    assign out_fire   = v_reg[DEPTH-1] & out_ready;
    assign count_next = out_fire ? count_reg + CNT_W'(1) : count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_reg     <= '0;
            count_reg <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                d_reg[s] <= '0;
            end
        end else begin
            v_reg     <= v_next;
            d_reg     <= d_next;
            count_reg <= count_next;
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v_reg[DEPTH-1];
    assign out_data  = d_reg[DEPTH-1];
    assign out_count = count_reg;

endmodule

// File: tb/tb_logic_pipe.sv
// tb_logic_pipe: table vectors, directed corner sequences and randomized traffic
// checked against a queue-of-items model of the elastic pipeline.
module tb_logic_pipe;
    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;

    always #5 clk = ~clk;

    logic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count)
    );

    typedef struct {
        logic [7:0] data;
        int         pos;
    } item_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] exp;
    } vec_t;

    item_t      mq[$];
    logic [7:0] got_q[$];
    int         m_count = 0;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         n_deliv = 0;

    function automatic logic [7:0] ref_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return ~a;
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return a ^ b;
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            3'd6:    return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare at the falling edge, advance the model at the rising edge.
    task automatic cycle(input logic iv, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic ordy, input logic r, output logic in_fire, output logic out_fire);
        logic  m_valid;
        logic  m_ready;
        int    limit;
        item_t t;
        rst = r; in_valid = iv; in_a = a; in_b = b; in_op = op; out_ready = ordy;
        @(negedge clk);
        m_valid = (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
        m_ready = ordy || (mq.size() < DEPTH);
        check("in_ready", in_ready, m_ready);
        check("out_valid", out_valid, m_valid);
        if (m_valid) check("out_data", out_data, mq[0].data);
        check("out_count", out_count, m_count);
        in_fire  = iv && m_ready && !r;
        out_fire = m_valid && ordy && !r;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_count = 0;
        end else begin
            if (out_fire) begin
                got_q.push_back(mq[0].data);
                n_deliv++;
                $display("deliver #%0d data=%02h", n_deliv, mq[0].data);
                void'(mq.pop_front());
                m_count = (m_count + 1) % (1 << CNT_W);
            end
            limit = DEPTH - 1;
            for (int i = 0; i < mq.size(); i++) begin
                t = mq[i];
                t.pos = (t.pos + 1 < limit) ? t.pos + 1 : limit;
                mq[i] = t;
                limit = t.pos - 1;
            end
            if (in_fire) begin
                t.data = ref_f(a, b, op);
                t.pos  = 0;
                mq.push_back(t);
            end
        end
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic ordy);
        logic fi;
        logic fo;
        int   n;
        n  = 0;
        fi = 1'b0;
        while (!fi && n < 20) begin
            cycle(1'b1, a, b, op, ordy, 1'b0, fi, fo);
            n++;
        end
        check("send_timeout", fi, 1'b1);
    endtask

    task automatic drain();
        logic fi;
        logic fo;
        int   n;
        n = 0;
        while (mq.size() > 0 && n < 20) begin
            cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, fi, fo);
            n++;
        end
        check("drain_timeout", mq.size(), 0);
    endtask

    initial begin
        vec_t       tbl[8];
        logic [7:0] exp_q[$];
        logic [7:0] ra;
        logic [7:0] rb;
        logic [2:0] rop;
        logic       fi;
        logic       fo;
        logic       piv;
        logic       pend;
        int         acc;
        int         n;

        tbl[0] = '{8'hC5, 8'h3A, 3'd0, 8'h3A};
        tbl[1] = '{8'hC5, 8'h3A, 3'd1, 8'h00};
        tbl[2] = '{8'hC5, 8'h3A, 3'd2, 8'hFF};
        tbl[3] = '{8'hC5, 8'h3A, 3'd3, 8'hFF};
        tbl[4] = '{8'hC5, 8'h3A, 3'd4, 8'hFF};
        tbl[5] = '{8'hC5, 8'h3A, 3'd5, 8'h00};
        tbl[6] = '{8'hC5, 8'h3A, 3'd6, 8'h00};
        tbl[7] = '{8'hC5, 8'h3A, 3'd7, 8'hC5};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state, observed while rst is still asserted
        cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, fi, fo);
        check("reset_out_data", out_data, 8'h00);
        check("reset_in_ready", in_ready, 1'b1);

        // Function sweep with fixed latency
        got_q.delete();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].op, 1'b1, 1'b0, fi, fo);
            if (i < 2) check("latency_early", out_valid, 1'b0);
            if (i == 2) check("latency_first", out_valid, 1'b1);
        end
        drain();
        check("sweep_count_len", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) check("sweep_table", got_q[i], tbl[i].exp);
        check("sweep_out_count", out_count, 8);

        // Backpressure fill
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(ref_f(8'(i * 37 + 5), 8'(i * 11), 3'(i + 1)));
        for (int i = 0; i < 3; i++) send(8'(i * 37 + 5), 8'(i * 11), 3'(i + 1), 1'b0);
        check("bp_in_ready_low", in_ready, 1'b0);
        check("bp_head_data", out_data, exp_q[0]);
        repeat (2) cycle(1'b1, 8'(3 * 37 + 5), 8'(3 * 11), 3'd4, 1'b0, 1'b0, fi, fo);
        check("bp_head_stable", out_data, exp_q[0]);
        for (int i = 3; i < 5; i++) send(8'(i * 37 + 5), 8'(i * 11), 3'(i + 1), 1'b1);
        drain();
        check("bp_len", got_q.size(), 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) check("bp_order", got_q[i], exp_q[i]);

        // Full pipe with simultaneous input and output transfers
        for (int i = 0; i < 3; i++) send(8'($urandom), 8'($urandom), 3'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b1, 1'b0, fi, fo);
            check("full_in_fire", fi, 1'b1);
            check("full_out_fire", fo, 1'b1);
            check("full_occupancy", mq.size(), 3);
        end
        drain();

        // Bubble compaction under backpressure
        acc = 0;
        n = 0;
        while (acc < 3 && n < 12) begin
            cycle(n % 2 == 0, 8'($urandom), 8'($urandom), 3'($urandom), 1'b0, 1'b0, fi, fo);
            if (fi) acc++;
            n++;
        end
        check("bubble_accepted", acc, 3);
        check("bubble_in_ready_low", in_ready, 1'b0);
        check("bubble_out_valid", out_valid, 1'b1);
        drain();

        // Counter wrap
        cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1, fi, fo);
        for (int i = 0; i < 16; i++) send(8'($urandom), 8'($urandom), 3'($urandom), 1'b1);
        drain();
        check("wrap_after_16", out_count, 0);
        send(8'h5A, 8'hA5, 3'd3, 1'b1);
        drain();
        check("wrap_after_17", out_count, 1);

        // Mid-stream reset with two items in flight
        send(8'h11, 8'h22, 3'd2, 1'b0);
        send(8'h33, 8'h44, 3'd1, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, fi, fo);
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_out_data", out_data, 8'h00);
        check("mrst_out_count", out_count, 0);
        check("mrst_in_ready", in_ready, 1'b1);
        got_q.delete();
        repeat (6) cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, fi, fo);
        check("mrst_no_stale", got_q.size(), 0);

        // Randomized traffic; the source holds an offered item until it is taken
        pend = 1'b0;
        piv = 1'b0;
        ra = '0; rb = '0; rop = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend) begin
                ra  = 8'($urandom);
                rb  = 8'($urandom);
                rop = 3'($urandom);
                piv = ($urandom_range(0, 3) != 0);
            end
            cycle(piv, ra, rb, rop, $urandom_range(0, 3) != 0, 1'b0, fi, fo);
            pend = piv && !fi;
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
